// File: rtl/rsa_pkg.sv
// Shared RSA constants and the controller state encoding, also used by the
// datapath and the bench.
package rsa_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_MUL, S_MOD, S_FINISH, S_RESP
  } rsa_state_t;

  localparam int RSA_N              = 3233;
  localparam int RSA_E              = 17;
  localparam int DEFAULT_MAX_ROUNDS = 32;
endpackage

// File: rtl/rsa_round_watchdog.sv
// Per-byte multiply/modulo round counter; flags the round that would reach
// the abort limit.
module rsa_round_watchdog #(
  parameter int MAX_ROUNDS = 32,
  parameter int ROUND_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  localparam logic [ROUND_W-1:0] LIMIT = ROUND_W'(MAX_ROUNDS);

  logic [ROUND_W-1:0] count, count_inc;

  assign count_inc = count + ROUND_W'(1);
  // Compare the post-increment value so the abort lands on the limiting round.
  assign expired   = inc && (count_inc == LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    count <= '0;
    else if (clr) count <= '0;
    else if (inc) count <= count_inc;
  end
endmodule

// File: rtl/rsa_controller.sv
// Sequencer for the RSA modular-exponentiation datapath: byte in, enable
// sequence out, result handshake, with a round watchdog.
module rsa_controller
  import rsa_pkg::*;
#(
  parameter int MAX_ROUNDS = DEFAULT_MAX_ROUNDS,
  parameter int ROUND_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err,
  output logic [15:0] byte_count,
  output logic [7:0]  dp_data,
  output logic        dp_initialize,
  output logic        dp_en_multiply,
  output logic        dp_en_modulo,
  output logic        dp_done,
  input  logic        dp_mult_done
);
  rsa_state_t state, state_nx;
  logic       accept, wd_expired;

  assign accept = (state == S_IDLE) && in_valid;

  rsa_round_watchdog #(.MAX_ROUNDS(MAX_ROUNDS), .ROUND_W(ROUND_W)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clr     (accept),
    .inc     (state == S_MOD),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      dp_data    <= '0;
      byte_count <= '0;
    end else begin
      state <= state_nx;
      if (accept) dp_data <= in_data;
      if (state == S_RESP && out_ready) byte_count <= byte_count + 16'd1;
    end
  end

  // All handshake and enable outputs are pure state decodes, so they are
  // mutually exclusive and fall to idle values as soon as reset asserts.
  always_comb begin
    state_nx       = state;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    err            = 1'b0;
    dp_initialize  = 1'b0;
    dp_en_multiply = 1'b0;
    dp_en_modulo   = 1'b0;
    dp_done        = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = S_INIT;
      end
      S_INIT: begin
        dp_initialize = 1'b1;
        state_nx      = S_MUL;
      end
      S_MUL: begin
        dp_en_multiply = 1'b1;
        state_nx       = S_MOD;
      end
      S_MOD: begin
        dp_en_modulo = 1'b1;
        if (dp_mult_done) begin
          state_nx = S_FINISH;
        end else if (wd_expired) begin
          err      = 1'b1;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_MUL;
        end
      end
      S_FINISH: begin
        dp_done  = 1'b1;
        state_nx = S_RESP;
      end
      S_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_rsa_controller.sv
// Bench for rsa_controller with a behavioural square-free multiply/modulo
// datapath model; vector table plus directed corner-case sequences.
module tb_rsa_controller;
  import rsa_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, err;
  logic [7:0]  in_data, dp_data;
  logic [15:0] byte_count;
  logic        dp_initialize, dp_en_multiply, dp_en_modulo, dp_done, dp_mult_done;

  logic        w_in_valid, w_in_ready, w_out_valid, w_err;
  logic [15:0] w_byte_count;
  logic [7:0]  w_dp_data;
  logic        w_init, w_mul, w_mod, w_done;

  always #5 clk = ~clk;

  rsa_controller dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .err(err),
    .byte_count(byte_count), .dp_data(dp_data), .dp_initialize(dp_initialize),
    .dp_en_multiply(dp_en_multiply), .dp_en_modulo(dp_en_modulo),
    .dp_done(dp_done), .dp_mult_done(dp_mult_done)
  );

  rsa_controller #(.MAX_ROUNDS(4), .ROUND_W(3)) u_wd (
    .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .in_data(in_data), .out_valid(w_out_valid), .out_ready(out_ready), .err(w_err),
    .byte_count(w_byte_count), .dp_data(w_dp_data), .dp_initialize(w_init),
    .dp_en_multiply(w_mul), .dp_en_modulo(w_mod), .dp_done(w_done),
    .dp_mult_done(1'b0)
  );

  // Datapath model: result starts at data, each multiply folds in data once
  // more, done after RSA_E-1 multiplies.
  logic [31:0] m_r;
  logic [7:0]  m_cnt;
  logic        m_done = 1'b0;
  logic [15:0] output_data = '0;
  assign dp_mult_done = m_done;

  always @(posedge clk) begin
    if (dp_initialize) begin
      m_r <= {24'd0, dp_data}; m_cnt <= 8'd1; m_done <= 1'b0;
    end else if (dp_en_multiply) begin
      m_r <= m_r * {24'd0, dp_data}; m_cnt <= m_cnt + 8'd1;
      m_done <= (int'(m_cnt) + 1 == RSA_E);
    end else if (dp_en_modulo) begin
      m_r <= m_r % RSA_N;
    end else if (dp_done) begin
      output_data <= m_r[15:0];
    end
  end

  int n_cmp = 0, n_bad = 0;
  int n_mul = 0, onehot_bad = 0, rv_bad = 0;
  int wc_mul = 0, wc_err = 0, wc_done = 0, wc_ov = 0;

  always @(negedge clk) begin
    if (dp_en_multiply) n_mul++;
    if ($countones({dp_initialize, dp_en_multiply, dp_en_modulo, dp_done}) > 1) onehot_bad++;
    if (in_ready && out_valid) rv_bad++;
    if (w_mul) wc_mul++;
    if (w_err) wc_err++;
    if (w_done) wc_done++;
    if (w_out_valid) wc_ov++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
  endtask

  // Called at a negedge with out_ready=1; returns result and accept-to-valid cycles.
  task automatic run_byte(input logic [7:0] b, output logic [15:0] res, output int lat);
    in_data = b; in_valid = 1'b1; n_mul = 0;
    wait_ready();
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    wait_out(lat);
    res = output_data;
    @(negedge clk);
  endtask

  typedef struct { logic [7:0] din; logic [15:0] res; } vec_t;
  vec_t vecs[5];
  logic [15:0] res, exp_bc;
  int lat;

  initial begin
    vecs[0] = '{8'd65, 16'd2790};
    vecs[1] = '{8'd0,  16'd0};
    vecs[2] = '{8'd1,  16'd1};
    vecs[3] = '{8'd2,  16'd1752};
    vecs[4] = '{8'd3,  16'd1211};

    reset = 1'b1; in_valid = 1'b0; w_in_valid = 1'b0; out_ready = 1'b1; in_data = 8'hA5;
    #12;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_byte_count", 32'(byte_count), 0);
    check("rst_dp_data", 32'(dp_data), 0);
    check("rst_enables", 32'({dp_initialize, dp_en_multiply, dp_en_modulo, dp_done}), 0);
    @(negedge clk); reset = 1'b0;
    exp_bc = 16'd0;

    for (int i = 0; i < 5; i++) begin
      run_byte(vecs[i].din, res, lat);
      exp_bc++;
      check($sformatf("vec%0d_result", i), 32'(res), 32'(vecs[i].res));
      check($sformatf("vec%0d_latency", i), 32'(lat), 35);
      check($sformatf("vec%0d_mul_pulses", i), 32'(n_mul), 16);
      check($sformatf("vec%0d_byte_count", i), 32'(byte_count), 32'(exp_bc));
      check($sformatf("vec%0d_idle", i), 32'(in_ready), 1);
    end

    // Back-to-back with in_valid held: 0 then 1.
    in_data = 8'd0; in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    @(negedge clk); in_data = 8'd1;
    wait_out(lat);
    check("b2b_first_result", 32'(output_data), 0);
    check("b2b_resp_not_ready", 32'(in_ready), 0);
    @(negedge clk); exp_bc++;
    check("b2b_idle_after_hs", 32'(in_ready), 1);
    check("b2b_count_first", 32'(byte_count), 32'(exp_bc));
    @(negedge clk); in_valid = 1'b0;
    check("b2b_second_init", 32'(dp_initialize), 1);
    check("b2b_second_data", 32'(dp_data), 1);
    wait_out(lat);
    check("b2b_second_result", 32'(output_data), 1);
    @(negedge clk); exp_bc++;
    check("b2b_count_second", 32'(byte_count), 32'(exp_bc));

    // Output stall for 10 cycles.
    out_ready = 1'b0; in_data = 8'd65; in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    wait_out(lat);
    check("stall_latency", 32'(lat), 35);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_byte_count", 32'(byte_count), 32'(exp_bc));
    end
    out_ready = 1'b1;
    @(negedge clk); exp_bc++;
    check("stall_result", 32'(output_data), 2790);
    check("stall_count", 32'(byte_count), 32'(exp_bc));
    check("stall_released", 32'(out_valid), 0);

    // Watchdog abort on the MAX_ROUNDS=4 instance.
    wc_mul = 0; wc_err = 0; wc_done = 0; wc_ov = 0;
    w_in_valid = 1'b1;
    @(negedge clk); w_in_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("wd_mul_pulses", 32'(wc_mul), 4);
    check("wd_err_cycles", 32'(wc_err), 1);
    check("wd_no_done", 32'(wc_done), 0);
    check("wd_no_out_valid", 32'(wc_ov), 0);
    check("wd_idle", 32'(w_in_ready), 1);
    check("wd_count", 32'(w_byte_count), 0);

    // Reset during round 5 (cycle 10 is its MUL).
    in_data = 8'd65; in_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_round5_mul", 32'(dp_en_multiply), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 1);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_byte_count", 32'(byte_count), 0);
    check("mid_rst_dp_data", 32'(dp_data), 0);
    check("mid_rst_enables", 32'({dp_initialize, dp_en_multiply, dp_en_modulo, dp_done}), 0);
    @(negedge clk); reset = 1'b0; exp_bc = 16'd0;
    run_byte(8'd65, res, lat);
    exp_bc++;
    check("post_rst_result", 32'(res), 2790);
    check("post_rst_latency", 32'(lat), 35);
    check("post_rst_count", 32'(byte_count), 32'(exp_bc));

    // Counter wrap: preload near the top, then two more bytes.
    force dut.byte_count = 16'hFFFE;
    @(negedge clk);
    release dut.byte_count;
    exp_bc = 16'hFFFE;
    run_byte(8'd2, res, lat);
    exp_bc++;
    check("wrap_ffff", 32'(byte_count), 32'(exp_bc));
    run_byte(8'd3, res, lat);
    exp_bc++;
    check("wrap_result", 32'(res), 1211);
    check("wrap_zero", 32'(byte_count), 0);

    check("enables_onehot", 32'(onehot_bad), 0);
    check("ready_valid_excl", 32'(rv_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
